regset_param: RTL and testbench
===============================

REGSET_PARAM -- requirements
Module: regset_param

Interface
- REQ-001: Parameter WIDTH SHALL be provided: default 16; register and bus width in bits, range 4..32.
- REQ-002: Parameter DEPTH SHALL be provided: default 4; number of registers, a power of two, range 2..16.
- REQ-003: Parameter RESET_VAL SHALL be provided: default all-ones of WIDTH; value loaded into every register on reset.
- REQ-004: Derived constant SELW SHALL equal log2(DEPTH).
- REQ-005: Port i_clk SHALL be: input, 1 bit; the single clock, all state updates on its rising edge.
- REQ-006: Port i_reset SHALL be: input, 1 bit; synchronous, active-high reset.
- REQ-007: Port io_bus SHALL be: inout, WIDTH bits; shared data bus, write source and read destination.
- REQ-008: Port i_writeSel SHALL be: input, SELW bits; index of the register to modify.
- REQ-009: Port i_we SHALL be: input, 1 bit; active-high modify enable.
- REQ-010: Port i_op SHALL be: input, 2 bits; modify operation (00 load, 01 increment, 10 decrement, 11 clear).
- REQ-011: Port i_outSel SHALL be: input, SELW bits; index of the register driven onto io_bus.
- REQ-012: Port i_noe SHALL be: input, 1 bit; active-low bus output enable.
- REQ-013: Port o_zero SHALL be: output, 1 bit; registered flag, result of the last modify was zero.
- REQ-014: Port o_carry SHALL be: output, 1 bit; registered carry (increment) or borrow (decrement) from the last modify.

Function
- REQ-015: When i_noe=0, io_bus SHALL be driven combinationally with register[i_outSel]; when i_noe=1, io_bus SHALL be high-impedance.
- REQ-016: When i_we=1 at a rising edge, only register[i_writeSel] SHALL update; all other registers SHALL hold.
- REQ-017: Load (00) SHALL capture the resolved io_bus value.
- REQ-018: Increment (01) SHALL store reg+1 modulo 2^WIDTH.
- REQ-019: Decrement (10) SHALL store reg-1 modulo 2^WIDTH.
- REQ-020: Clear (11) SHALL store 0.
- REQ-021: Increment wrap-around: all-ones SHALL become 0 and o_carry SHALL be set to 1.
- REQ-022: Decrement wrap-around: 0 SHALL become all-ones and o_carry SHALL be set to 1.
- REQ-023: Load and clear SHALL set o_carry to 0; any increment or decrement without wrap SHALL also set o_carry to 0.
- REQ-024: o_zero SHALL be set to 1 exactly when the value written by the modify is 0 (clear always sets it).
- REQ-025: Flags SHALL change only on a modify edge and SHALL hold while i_we=0.
- REQ-026: A modify SHALL have one-cycle latency; the new value SHALL be visible on io_bus (if selected and i_noe=0) right after the edge.
- REQ-027: Read and modify of the same register in one cycle SHALL drive the pre-edge value before the edge and the new value after it.
- REQ-028: Load with i_noe=0 SHALL copy register[i_outSel] into register[i_writeSel] (register move); load with i_outSel==i_writeSel SHALL leave the value unchanged.
- REQ-029: i_op SHALL be ignored while i_we=0.
- REQ-030: Signals io_bus, i_writeSel, i_outSel and i_op SHALL be treated as don't-care when their enables are inactive, with no state effect.

Reset
- REQ-031: i_reset=1 at a rising edge SHALL set every register to RESET_VAL, o_zero to (RESET_VAL==0), and o_carry to 0.
- REQ-032: Reset SHALL take priority over a simultaneous modify, including reset asserted mid-sequence.
- REQ-033: Reset SHALL not affect the combinational output drive; io_bus SHALL follow i_noe during and after reset.
- REQ-034: Register contents before the first reset SHALL be unspecified; the bench SHALL not check them.

Verification (WIDTH=16, DEPTH=4 unless stated)
- REQ-035: Reset, then read r0..r3 with i_noe=0 -> each reads 0xFFFF; o_zero=0, o_carry=0.
- REQ-036: External bus 0x1234, i_we=1, op=00, writeSel=2; then outSel=2, i_noe=0 -> bus reads 0x1234; r0, r1, r3 remain 0xFFFF.
- REQ-037: r1=0xFFFF, increment r1 -> r1=0x0000, o_zero=1, o_carry=1; increment again -> 0x0001, o_zero=0, o_carry=0.
- REQ-038: r3=0x0000, decrement r3 -> r3=0xFFFF, o_carry=1, o_zero=0.
- REQ-039: r0=0xABCD, outSel=0, i_noe=0, load with writeSel=3 -> r3=0xABCD; the same cycle's bus reads 0xABCD.
- REQ-040: Increment r2 with i_reset=1 on the same edge -> r2=0xFFFF, o_carry=0; repeat with WIDTH=8, DEPTH=8, RESET_VAL=0 -> all eight registers read 0x00 and o_zero=1.

Source files
------------

// File: rtl/regset_param_if.sv
// ---------------------------------------------------------------------------
// regset_param_if
//   Control/status bundle for regset_param. The bidirectional data bus stays
//   a plain inout net on the design because it is resolved from several
//   drivers. The master side (bench or host) drives the selects and enables.
//   The slave side (the register set) returns the registered flags.
//
//   i_writeSel : index of the register to modify
//   i_we       : active-high modify enable
//   i_op       : modify operation (00 load, 01 inc, 10 dec, 11 clear)
//   i_outSel   : index of the register driven onto the data bus
//   i_noe      : active-low bus output enable
//   o_zero     : last modify produced zero
//   o_carry    : carry/borrow of the last increment/decrement
// ---------------------------------------------------------------------------
interface regset_param_if #(
    parameter int SELW = 2
) ();
    logic [SELW-1:0] i_writeSel;
    logic            i_we;
    logic [1:0]      i_op;
    logic [SELW-1:0] i_outSel;
    logic            i_noe;
    logic            o_zero;
    logic            o_carry;

    modport master (
        output i_writeSel,
        output i_we,
        output i_op,
        output i_outSel,
        output i_noe,
        input  o_zero,
        input  o_carry
    );

    modport slave (
        input  i_writeSel,
        input  i_we,
        input  i_op,
        input  i_outSel,
        input  i_noe,
        output o_zero,
        output o_carry
    );
endinterface

// File: rtl/regset_param.sv
// ---------------------------------------------------------------------------
// regset_param
//   A bank of DEPTH registers, each WIDTH bits wide, that share a tristate
//   data bus. One register can be read onto the bus combinationally. One
//   register can be modified per clock edge with load, increment, decrement
//   or clear. The zero and carry/borrow flags of the last modify are kept in
//   flops.
//
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-high reset (registers <- RESET_VAL)
//   io_bus   : shared data bus, load source and read destination
//   ctrl     : selects, enables and flags (see regset_param_if)
// ---------------------------------------------------------------------------
module regset_param #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
    localparam int              SELW      = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    inout  wire  [WIDTH-1:0] io_bus,
    regset_param_if.slave    ctrl
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             zero_q;
    logic             zero_d;
    logic             carry_q;
    logic             carry_d;

    logic [WIDTH-1:0] rd_data_s;
    logic [WIDTH-1:0] load_data_s;
    logic [WIDTH-1:0] cur_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] new_s;
    logic             new_carry_s;

    // Read path and load source selection
    always_comb begin
        rd_data_s = regs_q[ctrl.i_outSel];
        // While we drive the bus ourselves, the resolved bus equals our own
        // read data, so a load becomes a register-to-register move. Taking
        // the value from the mux keeps the capture independent of how the
        // tristate net is resolved.
        if (ctrl.i_noe == 1'b0) begin
            load_data_s = rd_data_s;
        end else begin
            load_data_s = io_bus;
        end
    end

    assign io_bus = (ctrl.i_noe == 1'b0) ? rd_data_s : {WIDTH{1'bz}};

    // Next-state computation for the register file and the flags
    always_comb begin
        regs_d      = regs_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        cur_s       = regs_q[ctrl.i_writeSel];
        // One extra MSB captures carry-out on increment and borrow on
        // decrement. The borrow bit is set only when cur_s was zero.
        sum_s       = {1'b0, cur_s} + {{WIDTH{1'b0}}, 1'b1};
        diff_s      = {1'b0, cur_s} - {{WIDTH{1'b0}}, 1'b1};
        new_s       = cur_s;
        new_carry_s = 1'b0;

        case (ctrl.i_op)
            2'b00: begin
                new_s       = load_data_s;
                new_carry_s = 1'b0;
            end
            2'b01: begin
                new_s       = sum_s[WIDTH-1:0];
                new_carry_s = sum_s[WIDTH];
            end
            2'b10: begin
                new_s       = diff_s[WIDTH-1:0];
                new_carry_s = diff_s[WIDTH];
            end
            2'b11: begin
                new_s       = {WIDTH{1'b0}};
                new_carry_s = 1'b0;
            end
            default: begin
                new_s       = cur_s;
                new_carry_s = 1'b0;
            end
        endcase

        if (ctrl.i_we == 1'b1) begin
            regs_d[ctrl.i_writeSel] = new_s;
            zero_d                  = (new_s == {WIDTH{1'b0}});
            carry_d                 = new_carry_s;
        end else begin
            zero_d  = zero_q;
            carry_d = carry_q;
        end
    end

    // State registers; reset wins over a simultaneous modify
    always_ff @(posedge i_clk) begin
        if (i_reset == 1'b1) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            zero_q  <= (RESET_VAL == {WIDTH{1'b0}});
            carry_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign ctrl.o_zero  = zero_q;
    assign ctrl.o_carry = carry_q;

endmodule

// File: tb/tb_regset_param.sv
// ---------------------------------------------------------------------------
// tb_regset_param
//   Bench for regset_param. Instance A uses the default parameters and is
//   driven with directed and random steps that are checked against a
//   behavioural model. Instance B uses WIDTH=8, DEPTH=8, RESET_VAL=0.
// ---------------------------------------------------------------------------
module tb_regset_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: WIDTH=16, DEPTH=4 ----------------
    logic        rst_a;
    wire  [15:0] bus_a;
    logic [15:0] drv_a;
    logic        drv_en_a;
    assign bus_a = drv_en_a ? drv_a : 16'hzzzz;

    regset_param_if #(.SELW(2)) ifa ();

    regset_param #(.WIDTH(16), .DEPTH(4)) dut_a (
        .i_clk   (clk),
        .i_reset (rst_a),
        .io_bus  (bus_a),
        .ctrl    (ifa)
    );

    // ---------------- instance B: WIDTH=8, DEPTH=8, RESET_VAL=0 ----------------
    logic       rst_b;
    wire  [7:0] bus_b;

    regset_param_if #(.SELW(3)) ifb ();

    regset_param #(.WIDTH(8), .DEPTH(8), .RESET_VAL(8'h00)) dut_b (
        .i_clk   (clk),
        .i_reset (rst_b),
        .io_bus  (bus_b),
        .ctrl    (ifb)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model for instance A
    int unsigned mdl [4];
    bit          mdl_zero;
    bit          mdl_carry;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus on instance A, with the model applied at the edge
    task automatic step_a(input bit rst, input bit we, input bit [1:0] op,
                          input int ws, input int os, input bit noe,
                          input int unsigned dval);
        int unsigned old_v;
        int unsigned new_v;
        bit          c;
        @(negedge clk);
        rst_a           = rst;
        ifa.i_we        = we;
        ifa.i_op        = op;
        ifa.i_writeSel  = ws[1:0];
        ifa.i_outSel    = os[1:0];
        ifa.i_noe       = noe;
        drv_en_a        = noe;
        drv_a           = dval[15:0];
        #1;
        if (!noe) chk($sformatf("bus_pre_r%0d", os), {16'h0000, bus_a}, mdl[os]);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) mdl[i] = 32'h0000_FFFF;
            mdl_zero  = 1'b0;
            mdl_carry = 1'b0;
        end else if (we) begin
            old_v = mdl[ws];
            case (op)
                2'd0: begin
                    new_v = noe ? (dval & 32'h0000_FFFF) : mdl[os];
                    c     = 1'b0;
                end
                2'd1: begin
                    new_v = (old_v + 32'd1) % 32'd65536;
                    c     = (old_v == 32'd65535);
                end
                2'd2: begin
                    new_v = (old_v + 32'd65535) % 32'd65536;
                    c     = (old_v == 32'd0);
                end
                default: begin
                    new_v = 32'd0;
                    c     = 1'b0;
                end
            endcase
            mdl[ws]   = new_v;
            mdl_zero  = (new_v == 32'd0);
            mdl_carry = c;
        end
        #1;
        chk("zero", {31'h0, ifa.o_zero}, {31'h0, mdl_zero});
        chk("carry", {31'h0, ifa.o_carry}, {31'h0, mdl_carry});
        if (!noe) chk($sformatf("bus_post_r%0d", os), {16'h0000, bus_a}, mdl[os]);
    endtask

    task automatic rd_a(input int idx);
        step_a(1'b0, 1'b0, 2'b00, 0, idx, 1'b0, 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Main stimulus
    initial begin
        bit          r_rst;
        bit          r_we;
        bit [1:0]    r_op;
        bit          r_noe;
        int          r_ws;
        int          r_os;

        rst_a = 1'b0; drv_en_a = 1'b0; drv_a = 16'h0000;
        ifa.i_we = 1'b0; ifa.i_op = 2'b00; ifa.i_writeSel = 2'd0;
        ifa.i_outSel = 2'd0; ifa.i_noe = 1'b1;
        rst_b = 1'b0;
        ifb.i_we = 1'b0; ifb.i_op = 2'b00; ifb.i_writeSel = 3'd0;
        ifb.i_outSel = 3'd0; ifb.i_noe = 1'b1;

        // Reset, then read every register
        step_a(1'b1, 1'b0, 2'b00, 0, 0, 1'b1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_a(i);
            chk("reset_val", {16'h0000, bus_a}, 32'h0000_FFFF);
        end
        chk("reset_zero", {31'h0, ifa.o_zero}, 32'd0);
        chk("reset_carry", {31'h0, ifa.o_carry}, 32'd0);

        // External load into r2; the other registers stay put
        step_a(1'b0, 1'b1, 2'b00, 2, 0, 1'b1, 32'h1234);
        rd_a(2);
        chk("load_r2", {16'h0000, bus_a}, 32'h1234);
        rd_a(0); rd_a(1); rd_a(3);

        // Increment wrap on r1, then a plain increment
        step_a(1'b0, 1'b1, 2'b01, 1, 1, 1'b0, 32'd0);
        chk("r1_wrap_val", {16'h0000, bus_a}, 32'h0000);
        chk("r1_wrap_zero", {31'h0, ifa.o_zero}, 32'd1);
        chk("r1_wrap_carry", {31'h0, ifa.o_carry}, 32'd1);
        step_a(1'b0, 1'b1, 2'b01, 1, 1, 1'b0, 32'd0);
        chk("r1_inc_val", {16'h0000, bus_a}, 32'h0001);
        chk("r1_inc_carry", {31'h0, ifa.o_carry}, 32'd0);

        // Clear r3, then decrement wrap
        step_a(1'b0, 1'b1, 2'b11, 3, 3, 1'b0, 32'd0);
        chk("r3_clr_zero", {31'h0, ifa.o_zero}, 32'd1);
        step_a(1'b0, 1'b1, 2'b10, 3, 3, 1'b0, 32'd0);
        chk("r3_dec_val", {16'h0000, bus_a}, 32'hFFFF);
        chk("r3_dec_carry", {31'h0, ifa.o_carry}, 32'd1);
        chk("r3_dec_zero", {31'h0, ifa.o_zero}, 32'd0);

        // Register move r0 -> r3, and self-load is a no-op
        step_a(1'b0, 1'b1, 2'b00, 0, 1, 1'b1, 32'hABCD);
        step_a(1'b0, 1'b1, 2'b00, 3, 0, 1'b0, 32'd0);
        rd_a(3);
        chk("move_r3", {16'h0000, bus_a}, 32'hABCD);
        step_a(1'b0, 1'b1, 2'b00, 2, 2, 1'b0, 32'd0);
        chk("self_load_r2", {16'h0000, bus_a}, 32'h1234);

        // Reset beats a simultaneous increment on r2
        step_a(1'b1, 1'b1, 2'b01, 2, 2, 1'b0, 32'd0);
        chk("rst_prio_r2", {16'h0000, bus_a}, 32'hFFFF);
        chk("rst_prio_carry", {31'h0, ifa.o_carry}, 32'd0);

        // Random traffic, including occasional reset mid-sequence
        for (int n = 0; n < 400; n++) begin
            r_rst = ($urandom_range(39) == 0);
            r_we  = 1'($urandom_range(1));
            r_op  = 2'($urandom_range(3));
            r_ws  = int'($urandom_range(3));
            r_os  = int'($urandom_range(3));
            r_noe = 1'($urandom_range(1));
            step_a(r_rst, r_we, r_op, r_ws, r_os, r_noe, $urandom);
        end

        // Instance B: reset with a simultaneous increment, then read all
        @(negedge clk);
        rst_b = 1'b1; ifb.i_we = 1'b1; ifb.i_op = 2'b01;
        ifb.i_writeSel = 3'd5; ifb.i_outSel = 3'd0; ifb.i_noe = 1'b0;
        @(posedge clk); #1;
        chk("b_rst_zero", {31'h0, ifb.o_zero}, 32'd1);
        chk("b_rst_carry", {31'h0, ifb.o_carry}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst_b = 1'b0; ifb.i_we = 1'b0; ifb.i_outSel = 3'(i);
            #1;
            chk($sformatf("b_reset_r%0d", i), {24'h0, bus_b}, 32'h00);
        end
        @(negedge clk);
        ifb.i_we = 1'b1; ifb.i_op = 2'b01; ifb.i_writeSel = 3'd5; ifb.i_outSel = 3'd5;
        @(posedge clk); #1;
        chk("b_inc_r5", {24'h0, bus_b}, 32'h01);
        chk("b_inc_zero", {31'h0, ifb.o_zero}, 32'd0);
        @(negedge clk);
        ifb.i_op = 2'b10; ifb.i_writeSel = 3'd6; ifb.i_outSel = 3'd6;
        @(posedge clk); #1;
        chk("b_dec_r6", {24'h0, bus_b}, 32'hFF);
        chk("b_dec_carry", {31'h0, ifb.o_carry}, 32'd1);
        @(negedge clk);
        ifb.i_we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
